// File: rtl/shift_reg_univ_pkg.sv
// rtl/shift_reg_univ_pkg.sv - shared types and helpers for the universal shift register
//
// Purpose:
//   Operation-select encoding for shift_reg_univ and the classification
//   helper that tells the counter which operations count as shift events.
//
// Contents:
//   shift_mode_t  3-bit operation select (HOLD, SHL, SHR, LOAD, ROTL, ROTR, ASR, RSVD)
//   is_shift()    1 for the five operations that move bits (SHL, SHR, ROTL, ROTR, ASR)
//
// Configuration:
//   SHIFT_REG_UNIV_CNT_EN selects whether the shift counter is built (see shift_reg_univ).

package shift_reg_univ_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    LOAD = 3'd3,
    ROTL = 3'd4,
    ROTR = 3'd5,
    ASR  = 3'd6,
    RSVD = 3'd7
  } shift_mode_t;

  // LOAD, HOLD and the reserved code never advance the word counter.
  function automatic logic is_shift(input shift_mode_t mode);
    case (mode)
      SHL, SHR, ROTL, ROTR, ASR: is_shift = 1'b1;
      default:                   is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_reg_univ_cnt.sv
// rtl/shift_reg_univ_cnt.sv - word counter and word_done pulse for the universal shift register
//
// Purpose:
//   Counts shift events modulo WIDTH. The event that completes a word wraps
//   the count to 0 and raises word_done for exactly one cycle, aligned with
//   the cycle in which the register shows the completed word.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   en         in   operation enable; 0 holds the count and clears word_done
//   mode       in   operation select (shift_mode_t encoding)
//   shift_cnt  out  shift events since last load, reset or wrap
//   word_done  out  one-cycle pulse after the WIDTH-th shift event
//
// Configuration:
//   Instantiated by shift_reg_univ only when SHIFT_REG_UNIV_CNT_EN is defined.

module shift_reg_univ_cnt
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  shift_mode_t mode_q;
  logic        shift_evt;
  logic        wrap_evt;

  assign mode_q    = shift_mode_t'(mode);
  assign shift_evt = en && is_shift(mode_q);
  assign wrap_evt  = shift_evt && (shift_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      // word_done is a pulse: it only survives the edge that wrapped.
      word_done <= wrap_evt;
      if (en && mode_q == LOAD) begin
        shift_cnt <= '0;
      end else if (wrap_evt) begin
        shift_cnt <= '0;
      end else if (shift_evt) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift register with word counter
//
// Purpose:
//   WIDTH-bit register supporting hold, left/right shift, left/right rotate,
//   arithmetic right shift and parallel load. Serves as the serialiser /
//   deserialiser stage for serial-link and bit-bang blocks.
//
// Parameters:
//   WIDTH      register width, 2..64
//   RESET_VAL  register contents after reset
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   en           in   operation enable; 0 freezes register and counter
//   mode         in   operation select (shift_mode_t encoding)
//   ser_in_lsb   in   bit entering at bit 0 on SHL
//   ser_in_msb   in   bit entering at bit WIDTH-1 on SHR
//   par_in       in   parallel load data
//   par_out      out  current register contents
//   ser_out_msb  out  par_out[WIDTH-1]
//   ser_out_lsb  out  par_out[0]
//   shift_cnt    out  shift events since last load, reset or wrap
//   word_done    out  one-cycle pulse when par_out shows a completed word
//
// Configuration:
//   SHIFT_REG_UNIV_CNT_EN defined   -> shift_reg_univ_cnt is instantiated.
//   SHIFT_REG_UNIV_CNT_EN undefined -> shift_cnt and word_done tied to 0;
//                                      register behaviour is identical.

module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic                         ser_in_lsb,
  input  logic                         ser_in_msb,
  input  logic [WIDTH-1:0]             par_in,
  output logic [WIDTH-1:0]             par_out,
  output logic                         ser_out_msb,
  output logic                         ser_out_lsb,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         word_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  shift_mode_t      mode_q;

  assign mode_q = shift_mode_t'(mode);

  // Next-state mux; HOLD and the reserved code both fall to the default.
  always_comb begin
    data_d = data_q;
    case (mode_q)
      SHL:     data_d = {data_q[WIDTH-2:0], ser_in_lsb};
      SHR:     data_d = {ser_in_msb, data_q[WIDTH-1:1]};
      LOAD:    data_d = par_in;
      ROTL:    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      ROTR:    data_d = {data_q[0], data_q[WIDTH-1:1]};
      ASR:     data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (en) begin
      data_q <= data_d;
    end
  end

  assign par_out     = data_q;
  assign ser_out_msb = data_q[WIDTH-1];
  assign ser_out_lsb = data_q[0];

`ifdef SHIFT_REG_UNIV_CNT_EN
  shift_reg_univ_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );
`else
  assign shift_cnt = '0;
  assign word_done = 1'b0;
`endif

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: WIDTH-bit storage with hold, left/right shift, left/right rotate, arithmetic right shift and parallel load, plus a shift counter that flags each completed word. It is the general-purpose serialiser/deserialiser stage for the serial-link and bit-bang blocks. It replaces fixed-width, left-shift-only registers wherever a design needs parallel access or direction control.

## Interface
- WIDTH, 8: register width in bits; legal range 2..64.
- RESET_VAL, '0: register contents after reset, WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  operation enable; when 0 the register, counter and word_done hold or clear as described below.
- mode  in  3  operation select (shift_mode_t).
- ser_in_lsb  in  1  serial bit entering at bit 0 on SHL.
- ser_in_msb  in  1  serial bit entering at bit WIDTH-1 on SHR.
- par_in  in  WIDTH  parallel load data.
- par_out  out  WIDTH  current register contents.
- ser_out_msb  out  1  par_out[WIDTH-1].
- ser_out_lsb  out  1  par_out[0].
- shift_cnt  out  $clog2(WIDTH+1)  shifts since last load, reset or wrap.
- word_done  out  1  one-cycle pulse after the WIDTH-th shift.

## Operation
- Reset: one clock, synchronous and active-high, named clk and rst.
- mode encoding (applies when en=1):
  - 0 HOLD: no change.
  - 1 SHL: {r[W-2:0], ser_in_lsb}.
  - 2 SHR: {ser_in_msb, r[W-1:1]}.
  - 3 LOAD: par_in.
  - 4 ROTL: {r[W-2:0], r[W-1]}.
  - 5 ROTR: {r[0], r[W-1:1]}.
  - 6 ASR: {r[W-1], r[W-1:1]}.
  - 7: reserved; behaves as HOLD and never counts.
- en=0: register and shift_cnt hold, and word_done is 0 that cycle.
- Priority: rst over everything, then en, then mode.
- Counter: modes 1, 2, 4, 5 and 6 with en=1 are "shift events".
  - Each shift event increments shift_cnt.
  - The shift event that takes shift_cnt from WIDTH-1 wraps it to 0 and sets word_done=1 on the following cycle only.
  - LOAD clears shift_cnt to 0 and never raises word_done.
  - HOLD and reserved modes leave shift_cnt unchanged.
- Direction changes mid-word do not reset the counter; every shift event counts regardless of direction.

## Timing
- Reset values: par_out=RESET_VAL, ser_out_msb=RESET_VAL[W-1], ser_out_lsb=RESET_VAL[0], shift_cnt=0, word_done=0.
- All state updates on the rising edge of clk. par_out reflects the operation one cycle after it is presented.
- Serial outputs are combinational from the register, with no extra register stage.
- word_done is registered: asserted exactly the cycle in which par_out shows the completed word.
- Reset asserted mid-word: the next edge restores reset values and any pending word_done is dropped.
- LOAD on the same edge as the wrapping shift is impossible because mode is single-valued. A LOAD in the cycle word_done is high does not suppress that pulse.
- Back-to-back words: continuous shifting yields word_done every WIDTH cycles with no gap.

## Configuration
- SHIFT_REG_UNIV_CNT_EN defined: the counter and word_done logic are present as described.
- SHIFT_REG_UNIV_CNT_EN undefined: the counter logic is removed, shift_cnt is tied to 0 and word_done to 0. Register behaviour is unchanged.

## Structure
- Package shift_reg_univ_pkg holds:
  - typedef enum logic [2:0] shift_mode_t (HOLD, SHL, SHR, LOAD, ROTL, ROTR, ASR, RSVD).
  - Function is_shift(mode), returning true for the five shift-event modes.
- Sub-module shift_reg_univ_cnt contains the wrap counter and word_done register. It is parametrised by WIDTH and instantiated only under SHIFT_REG_UNIV_CNT_EN.
- Datapath mux and register stay in the top module.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=8'h00, with SHIFT_REG_UNIV_CNT_EN defined unless stated.
- Reset/LOAD: assert rst 2 cycles, then LOAD par_in=8'hA5 → par_out=8'h00 during reset, 8'hA5 the cycle after LOAD, shift_cnt=0.
- Serialise: LOAD 8'hA5, then 8×SHL with ser_in_lsb=0 → ser_out_msb sequence 1,0,1,0,0,1,0,1; word_done high only in the cycle par_out=8'h00; shift_cnt reads 0 then.
- Deserialise: 8×SHR feeding ser_in_msb bits 1,1,0,0,1,0,1,0 → par_out=8'h53, word_done one cycle.
- Rotate/ASR: LOAD 8'h81; ROTL → 8'h03; ROTR → 8'h81; ASR → 8'hC0; ASR → 8'hE0; shift_cnt=4.
- Enable/reserved/reset mid-word: 3 SHL, en=0 for 2 cycles, mode=7 for 2 cycles, rst for 1 cycle → state frozen while en=0 or mode=7; after rst, shift_cnt=0, par_out=8'h00, no word_done.
- Macro off: build without SHIFT_REG_UNIV_CNT_EN, run the Serialise scenario → identical par_out and serial outputs; shift_cnt and word_done constant 0.
